serial_uart_core: RTL and testbench



---
 rtl/serial_uart_core_if.sv | 20 ++
 rtl/serial_uart_core.sv | 326 ++++++++++++++++++++++++++++++++
 tb/tb_serial_uart_core.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_uart_core_if.sv
// CPU-side bus of one serial_uart_core instance: port enable, register
// address, read/write select, write data, registered read data and IRQ.
interface serial_uart_core_if;
    logic       Port_Enable;
    logic [3:0] Address;
    logic       WE_L;
    logic [7:0] DataIn;
    logic [7:0] DataOut;
    logic       IRQ_H;

    modport master (
        output Port_Enable, Address, WE_L, DataIn,
        input  DataOut, IRQ_H
    );

    modport slave (
        input  Port_Enable, Address, WE_L, DataIn,
        output DataOut, IRQ_H
    );
endinterface

// File: rtl/serial_uart_core.sv
// Simplified 16550-style UART, fixed 8N1: TX FIFO + shifter, RX shifter with
// one holding register, 16x baud generator and line status register.
module serial_uart_core #(
    parameter int TX_DEPTH        = 16,
    parameter int DEFAULT_DIVISOR = 27
) (
    input  logic                Clock,
    input  logic                Reset_L,
    serial_uart_core_if.slave   bus,
    input  logic                RxD,
    output logic                TxD
);
    localparam int             PTR_W       = $clog2(TX_DEPTH);
    localparam logic [PTR_W:0] FIFO_FULL_C = (PTR_W + 1)'(TX_DEPTH);
    localparam logic [15:0]    DIV_RST_C   = 16'(DEFAULT_DIVISOR);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    // Registered state
    logic             pe_q;
    logic [7:0]       dout_q, dout_d;
    logic [7:0]       dll_q, dll_d, dlm_q, dlm_d;
    logic [15:0]      baud_cnt_q, baud_cnt_d;
    logic [7:0]       fifo_mem_q [TX_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    tx_state_e        tx_state_q, tx_state_d;
    logic [3:0]       tx_sub_q, tx_sub_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic             txd_q, txd_d;
    logic             rx_sync1_q, rx_sync2_q;
    rx_state_e        rx_state_q, rx_state_d;
    logic [3:0]       rx_sub_q, rx_sub_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic [7:0]       rbr_q, rbr_d;
    logic             dr_q, dr_d, oe_q, oe_d, fe_q, fe_d;

    // Combinational helpers
    logic       strobe_s, wr_stb_s, rd_stb_s, rbr_rd_s, lsr_rd_s;
    logic [2:0] reg_idx_s;
    logic [15:0] divisor_s;
    logic       tick_s, fifo_empty_s, fifo_full_s, push_s, pop_s;
    logic       rx_done_s;
    logic [7:0] lsr_s, rd_sel_s;
    logic       unused_a0_s;

    assign unused_a0_s  = bus.Address[0];
    assign strobe_s     = bus.Port_Enable & ~pe_q;
    assign reg_idx_s    = bus.Address[3:1];
    assign wr_stb_s     = strobe_s & ~bus.WE_L;
    assign rd_stb_s     = strobe_s &  bus.WE_L;
    assign rbr_rd_s     = rd_stb_s && (reg_idx_s == 3'd0);
    assign lsr_rd_s     = rd_stb_s && (reg_idx_s == 3'd5);
    assign divisor_s    = {dlm_q, dll_q};
    assign tick_s       = (baud_cnt_q == 16'd0) && (divisor_s != 16'd0);
    assign fifo_empty_s = (count_q == '0);
    assign fifo_full_s  = (count_q == FIFO_FULL_C);
    // A push into a full FIFO is still accepted when a pop frees a slot this cycle.
    assign push_s       = wr_stb_s && (reg_idx_s == 3'd0) && (!fifo_full_s || pop_s);
    assign lsr_s        = {1'b0, fifo_empty_s && (tx_state_q == TX_IDLE), fifo_empty_s,
                           1'b0, fe_q, 1'b0, oe_q, dr_q};

    assign bus.DataOut  = dout_q;
    assign bus.IRQ_H    = dr_q;
    assign TxD          = txd_q;

    // Baud counter: reload with divisor-1 at zero; a zero divisor parks it at zero.
    always_comb begin
        baud_cnt_d = baud_cnt_q;
        if (baud_cnt_q != 16'd0) begin
            baud_cnt_d = baud_cnt_q - 16'd1;
        end else if (divisor_s != 16'd0) begin
            baud_cnt_d = divisor_s - 16'd1;
        end else begin
            baud_cnt_d = 16'd0;
        end
    end

    // Divisor writes and registered read-data mux.
    always_comb begin
        dll_d = dll_q;
        dlm_d = dlm_q;
        if (wr_stb_s) begin
            case (reg_idx_s)
                3'd1:    dll_d = bus.DataIn;
                3'd2:    dlm_d = bus.DataIn;
                default: dll_d = dll_q;
            endcase
        end else begin
            dlm_d = dlm_q;
        end
        case (reg_idx_s)
            3'd0:    rd_sel_s = rbr_q;
            3'd1:    rd_sel_s = dll_q;
            3'd2:    rd_sel_s = dlm_q;
            3'd5:    rd_sel_s = lsr_s;
            default: rd_sel_s = 8'h00;
        endcase
        if (bus.Port_Enable && bus.WE_L) begin
            dout_d = rd_sel_s;
        end else begin
            dout_d = dout_q;
        end
    end

    // TX FSM: each bit lasts 16 ticks; back-to-back frames go STOP -> START.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_sub_d   = tx_sub_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        pop_s      = 1'b0;
        if (tick_s) begin
            case (tx_state_q)
                TX_IDLE: begin
                    if (!fifo_empty_s) begin
                        pop_s      = 1'b1;
                        tx_shift_d = fifo_mem_q[rd_ptr_q];
                        tx_state_d = TX_START;
                        tx_sub_d   = 4'd0;
                    end else begin
                        tx_state_d = TX_IDLE;
                    end
                end
                TX_START: begin
                    if (tx_sub_q == 4'd15) begin
                        tx_state_d = TX_DATA;
                        tx_sub_d   = 4'd0;
                        tx_bit_d   = 3'd0;
                    end else begin
                        tx_sub_d = tx_sub_q + 4'd1;
                    end
                end
                TX_DATA: begin
                    if (tx_sub_q == 4'd15) begin
                        tx_sub_d   = 4'd0;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        if (tx_bit_q == 3'd7) begin
                            tx_state_d = TX_STOP;
                        end else begin
                            tx_bit_d = tx_bit_q + 3'd1;
                        end
                    end else begin
                        tx_sub_d = tx_sub_q + 4'd1;
                    end
                end
                TX_STOP: begin
                    if (tx_sub_q == 4'd15) begin
                        tx_sub_d = 4'd0;
                        if (!fifo_empty_s) begin
                            pop_s      = 1'b1;
                            tx_shift_d = fifo_mem_q[rd_ptr_q];
                            tx_state_d = TX_START;
                        end else begin
                            tx_state_d = TX_IDLE;
                        end
                    end else begin
                        tx_sub_d = tx_sub_q + 4'd1;
                    end
                end
                default: tx_state_d = TX_IDLE;
            endcase
        end else begin
            tx_state_d = tx_state_q;
        end
        case (tx_state_d)
            TX_START: txd_d = 1'b0;
            TX_DATA:  txd_d = tx_shift_d[0];
            default:  txd_d = 1'b1;
        endcase
    end

    // FIFO pointers and occupancy.
    always_comb begin
        wr_ptr_d = push_s ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_s  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // RX FSM: confirm start at mid-bit, then sample every 16 ticks.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_sub_d   = rx_sub_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_done_s  = 1'b0;
        if (tick_s) begin
            case (rx_state_q)
                RX_IDLE: begin
                    if (!rx_sync2_q) begin
                        rx_state_d = RX_START;
                        rx_sub_d   = 4'd0;
                    end else begin
                        rx_state_d = RX_IDLE;
                    end
                end
                RX_START: begin
                    if (rx_sub_q == 4'd7) begin
                        rx_sub_d   = 4'd0;
                        rx_bit_d   = 3'd0;
                        rx_state_d = rx_sync2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_sub_d = rx_sub_q + 4'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_sub_q == 4'd15) begin
                        rx_sub_d   = 4'd0;
                        rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
                        if (rx_bit_q == 3'd7) begin
                            rx_state_d = RX_STOP;
                        end else begin
                            rx_bit_d = rx_bit_q + 3'd1;
                        end
                    end else begin
                        rx_sub_d = rx_sub_q + 4'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_sub_q == 4'd15) begin
                        rx_sub_d   = 4'd0;
                        rx_done_s  = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_sub_d = rx_sub_q + 4'd1;
                    end
                end
                default: rx_state_d = RX_IDLE;
            endcase
        end else begin
            rx_state_d = rx_state_q;
        end
    end

    // Holding register and status flags; a same-cycle RBR read frees the slot first.
    always_comb begin
        rbr_d = rbr_q;
        dr_d  = rbr_rd_s ? 1'b0 : dr_q;
        oe_d  = lsr_rd_s ? 1'b0 : oe_q;
        fe_d  = lsr_rd_s ? 1'b0 : fe_q;
        if (rx_done_s) begin
            if (!dr_q || rbr_rd_s) begin
                rbr_d = rx_shift_q;
                dr_d  = 1'b1;
            end else begin
                oe_d = 1'b1;
            end
            if (!rx_sync2_q) begin
                fe_d = 1'b1;
            end else begin
                fe_d = fe_d;
            end
        end else begin
            rbr_d = rbr_q;
        end
    end

    // TX FIFO storage.
    always_ff @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) begin
            for (int i = 0; i < TX_DEPTH; i++) fifo_mem_q[i] <= 8'h00;
        end else if (push_s) begin
            fifo_mem_q[wr_ptr_q] <= bus.DataIn;
        end
    end

    // All control and datapath registers.
    always_ff @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) begin
            pe_q       <= 1'b0;
            dout_q     <= 8'h00;
            dll_q      <= DIV_RST_C[7:0];
            dlm_q      <= DIV_RST_C[15:8];
            baud_cnt_q <= 16'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tx_state_q <= TX_IDLE;
            tx_sub_q   <= 4'd0;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'h00;
            txd_q      <= 1'b1;
            rx_sync1_q <= 1'b1;
            rx_sync2_q <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_sub_q   <= 4'd0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'h00;
            rbr_q      <= 8'h00;
            dr_q       <= 1'b0;
            oe_q       <= 1'b0;
            fe_q       <= 1'b0;
        end else begin
            pe_q       <= bus.Port_Enable;
            dout_q     <= dout_d;
            dll_q      <= dll_d;
            dlm_q      <= dlm_d;
            baud_cnt_q <= baud_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tx_state_q <= tx_state_d;
            tx_sub_q   <= tx_sub_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
            rx_sync1_q <= RxD;
            rx_sync2_q <= rx_sync1_q;
            rx_state_q <= rx_state_d;
            rx_sub_q   <= rx_sub_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rbr_q      <= rbr_d;
            dr_q       <= dr_d;
            oe_q       <= oe_d;
            fe_q       <= fe_d;
        end
    end
endmodule

// File: tb/tb_serial_uart_core.sv
// Directed bench for serial_uart_core: register access, TX framing, FIFO
// overflow, RX status flags, false start, strobe behaviour and reset.
module tb_serial_uart_core;
    logic clk = 1'b0;
    logic rst_n;
    logic rxd;
    logic txd;
    int   checks = 0;
    int   errors = 0;

    serial_uart_core_if bus_if ();

    serial_uart_core #(.TX_DEPTH(16), .DEFAULT_DIVISOR(27)) dut (
        .Clock   (clk),
        .Reset_L (rst_n),
        .bus     (bus_if.slave),
        .RxD     (rxd),
        .TxD     (txd)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts and reports mismatches.
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] idx, input logic [7:0] data);
        @(negedge clk);
        bus_if.Port_Enable = 1'b1;
        bus_if.WE_L        = 1'b0;
        bus_if.Address     = {idx, 1'b0};
        bus_if.DataIn      = data;
        @(negedge clk);
        bus_if.Port_Enable = 1'b0;
        bus_if.WE_L        = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] idx, output logic [7:0] data);
        @(negedge clk);
        bus_if.Port_Enable = 1'b1;
        bus_if.WE_L        = 1'b1;
        bus_if.Address     = {idx, 1'b1};
        @(negedge clk);
        data               = bus_if.DataOut;
        bus_if.Port_Enable = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [2:0] idx, input logic [7:0] exp);
        logic [7:0] d;
        bus_read(idx, d);
        check_eq(tag, d, exp);
    endtask

    // Receive one TX frame at divisor 1 (16 cycles per bit), sampling mid-bit.
    task automatic recv_tx(input int max_wait, output logic [7:0] data, output int waited,
                           output int start_lows, output logic stop_bit, output logic timeout);
        waited = 0; timeout = 1'b1; start_lows = 0; data = 8'h00; stop_bit = 1'b0;
        for (int i = 0; i < max_wait; i++) begin
            @(negedge clk);
            waited++;
            if (txd == 1'b0) begin
                timeout = 1'b0;
                break;
            end
        end
        if (!timeout) begin
            start_lows = 1;
            repeat (15) begin
                @(negedge clk);
                if (txd == 1'b0) start_lows++;
            end
            repeat (9) @(negedge clk);
            data[0] = txd;
            for (int b = 1; b < 8; b++) begin
                repeat (16) @(negedge clk);
                data[b] = txd;
            end
            repeat (16) @(negedge clk);
            stop_bit = txd;
        end
    endtask

    // Drive one 8N1 frame on RxD at divisor 1, followed by one idle bit time.
    task automatic send_rx(input logic [7:0] data, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, data, 1'b0};
        for (int b = 0; b < 10; b++) begin
            rxd = frame[b];
            repeat (16) @(negedge clk);
        end
        rxd = 1'b1;
        repeat (16) @(negedge clk);
    endtask

    task automatic count_tx_lows(input int cycles, output int lows);
        lows = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (txd == 1'b0) lows++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] d;
        int         waited, lows, start_lows;
        logic       stop_bit, timeout;

        bus_if.Port_Enable = 1'b0;
        bus_if.WE_L        = 1'b1;
        bus_if.Address     = 4'h0;
        bus_if.DataIn      = 8'h00;
        rxd                = 1'b1;
        rst_n              = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check_eq("rst_txd", txd, 1'b1);
        check_eq("rst_irq", bus_if.IRQ_H, 1'b0);
        check_eq("rst_dout", bus_if.DataOut, 8'h00);
        rst_n = 1'b1;
        read_check("rst_lsr", 3'd5, 8'h60);
        read_check("rst_dll", 3'd1, 8'h1B);
        read_check("rst_dlm", 3'd2, 8'h00);
        read_check("idx3_read", 3'd3, 8'h00);
        bus_write(3'd3, 8'hFF);
        read_check("idx3_after_wr", 3'd3, 8'h00);
        bus_write(3'd1, 8'h01);
        read_check("dll_wr", 3'd1, 8'h01);
        repeat (4) @(negedge clk);
        check_eq("dout_hold", bus_if.DataOut, 8'h01);
        repeat (40) @(negedge clk);

        // Single frame 0xA5
        bus_write(3'd0, 8'hA5);
        recv_tx(100, d, waited, start_lows, stop_bit, timeout);
        check_eq("a5_timeout", timeout, 1'b0);
        check_eq("a5_start_len", start_lows, 16);
        check_eq("a5_data", d, 8'hA5);
        check_eq("a5_stop", stop_bit, 1'b1);
        repeat (12) @(negedge clk);
        read_check("a5_temt", 3'd5, 8'h60);

        // 17 pushes with TX frozen: 16 kept, 0x10 dropped
        bus_write(3'd1, 8'h00);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 17; i++) bus_write(3'd0, 8'(i));
        read_check("full_lsr", 3'd5, 8'h00);
        bus_write(3'd1, 8'h01);
        for (int f = 0; f < 16; f++) begin
            recv_tx(200, d, waited, start_lows, stop_bit, timeout);
            check_eq($sformatf("burst%0d_timeout", f), timeout, 1'b0);
            check_eq($sformatf("burst%0d_data", f), d, 8'(f));
            check_eq($sformatf("burst%0d_stop", f), stop_bit, 1'b1);
            if (f > 0) check_eq($sformatf("burst%0d_gap", f), waited, 8);
        end
        count_tx_lows(200, lows);
        check_eq("burst_no_17th", lows, 0);
        read_check("burst_lsr_end", 3'd5, 8'h60);

        // Port_Enable held 5 cycles on a THR write: exactly one push
        bus_write(3'd1, 8'h00);
        repeat (3) @(negedge clk);
        @(negedge clk);
        bus_if.Port_Enable = 1'b1;
        bus_if.WE_L        = 1'b0;
        bus_if.Address     = 4'h0;
        bus_if.DataIn      = 8'h77;
        repeat (5) @(negedge clk);
        bus_if.Port_Enable = 1'b0;
        bus_if.WE_L        = 1'b1;
        read_check("hold_lsr", 3'd5, 8'h00);
        bus_write(3'd1, 8'h01);
        recv_tx(100, d, waited, start_lows, stop_bit, timeout);
        check_eq("hold_data", d, 8'h77);
        count_tx_lows(200, lows);
        check_eq("hold_single_push", lows, 0);
        read_check("hold_lsr_end", 3'd5, 8'h60);

        // RX: clean frame, then RBR read clears DR
        send_rx(8'h3C, 1'b1);
        check_eq("rx1_irq", bus_if.IRQ_H, 1'b1);
        read_check("rx1_lsr", 3'd5, 8'h61);
        read_check("rx1_rbr", 3'd0, 8'h3C);
        check_eq("rx1_irq_clr", bus_if.IRQ_H, 1'b0);

        // RX overrun: second byte discarded, old byte kept
        send_rx(8'h3C, 1'b1);
        send_rx(8'h55, 1'b1);
        check_eq("ovr_irq", bus_if.IRQ_H, 1'b1);
        read_check("ovr_lsr", 3'd5, 8'h63);
        read_check("ovr_lsr_clr", 3'd5, 8'h61);
        read_check("ovr_rbr", 3'd0, 8'h3C);
        read_check("ovr_lsr_end", 3'd5, 8'h60);

        // 4-cycle glitch is a false start
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        repeat (40) @(negedge clk);
        read_check("glitch_lsr", 3'd5, 8'h60);
        check_eq("glitch_irq", bus_if.IRQ_H, 1'b0);

        // Framing error: byte stored and FE raised
        send_rx(8'h96, 1'b0);
        read_check("fe_lsr", 3'd5, 8'h69);
        read_check("fe_rbr", 3'd0, 8'h96);
        read_check("fe_lsr_clr", 3'd5, 8'h60);

        // Reset mid-frame
        bus_write(3'd0, 8'h81);
        waited = 0;
        while (txd !== 1'b0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check_eq("rst_mid_started", txd, 1'b0);
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_txd", txd, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        read_check("rst_mid_lsr", 3'd5, 8'h60);
        read_check("rst_mid_dll", 3'd1, 8'h1B);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
